seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative restoring divider; the inverse operation of the configurable multiplier datapath.
- Takes an unsigned dividend and divisor and produces the quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so it can sit beside the multiplier in the same arithmetic unit.
- Its per-iteration trial subtraction is a ripple-borrow subtractor, the dual of the team's ripple-carry adder.

Parameters:
DATA_SIZE, 8, width of dividend, divisor, quotient and remainder (must be >= 2)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; asynchronous, active-high
start_i  input  1  request; sampled only in IDLE or DONE
dividend_i  input  DATA_SIZE  dividend, captured on the accepting edge
divisor_i  input  DATA_SIZE  divisor, captured on the accepting edge
busy_o  output  1  high while in CALC
done_o  output  1  one-cycle pulse; results valid
quotient_o  output  DATA_SIZE  quotient, held until the next accept
remainder_o  output  DATA_SIZE  remainder, held until the next accept
div_by_zero_o  output  1  set with done_o when divisor was 0; held with the results

Behaviour:
Reset:
- rst_i high asynchronously forces state IDLE and clears every output and internal register, including the iteration counter.
- Reset mid-CALC aborts the operation; no done_o pulse follows.

States: IDLE, CALC, DONE.
- IDLE or DONE, start_i=1, divisor_i!=0: capture operands, clear the partial remainder, counter=0, go to CALC.
- IDLE or DONE, start_i=1, divisor_i=0: go directly to DONE. Result: quotient all ones, remainder = dividend_i, div_by_zero_o=1.
- CALC: each cycle, shift {remainder, dividend} left by one, then trial-subtract the divisor from the (DATA_SIZE+1)-bit partial remainder.
  - No borrow: keep the difference and write quotient bit 1.
  - Borrow: restore the partial remainder and write quotient bit 0.
  - counter increments each cycle; after DATA_SIZE iterations go to DONE.
- DONE: done_o=1 for exactly this cycle, then go to IDLE.
  - A start_i in DONE is accepted, allowing back-to-back operations.

Timing:
- done_o goes high DATA_SIZE cycles after the accepting edge (8 for the default); divide-by-zero takes 1 cycle.
- busy_o=1 exactly in CALC.
- start_i in CALC is ignored; captured operands are unaffected.

Results:
- quotient_o, remainder_o and div_by_zero_o update only on entry to DONE.
- They hold their values through IDLE.
- div_by_zero_o clears on the next accept.
- Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
SIGNED_DIV_EN
- Defined: operands are two's complement.
  - Magnitudes are taken on capture; the sign is fixed up when results are written on entry to DONE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1 yields quotient=MIN, remainder=0.
  - Divide-by-zero behaves as above. Latency is unchanged.
- Undefined: purely unsigned operation; no sign logic is synthesised.

Decomposition:
- Package divider_pkg:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - counter width function clog2(DATA_SIZE+1).
- Sub-module ripple_borrow_subtractor, parameter DATA_SIZE:
  - combinational a_i - b_i with diff_o and borrow_o;
  - built from a full-subtractor chain and used for the trial subtraction at width DATA_SIZE+1.

Test Plan (DATA_SIZE=8):
- 200/7 -> 8 cycles after the accept: done_o pulse, quotient 28, remainder 4, busy_o high for exactly 8 cycles.
- 5/0 -> done_o the next cycle, quotient 255, remainder 5, div_by_zero_o=1; then 9/3 -> quotient 3, remainder 0, div_by_zero_o=0.
- Boundaries: 3/10 -> q 0, r 3; 255/1 -> q 255, r 0; 255/255 -> q 1, r 0.
- start_i pulsed mid-CALC with other operands -> ignored, original result delivered. start_i held high in DONE -> back-to-back result 8 cycles later.
- rst_i asserted at iteration 4 -> all outputs 0 immediately, no done_o. A new 100/9 after release -> q 11, r 1.
- SIGNED_DIV_EN: -100/7 -> q 0xF2 (-14), r 0xFE (-2); -128/-1 -> q 0x80, r 0.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// iteration-counter sizing helper.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int data_size);
        return $clog2(data_size + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the restoring divider.
interface seq_restoring_divider_if #(parameter int DATA_SIZE = 8);

    logic                 start_i;
    logic [DATA_SIZE-1:0] dividend_i;
    logic [DATA_SIZE-1:0] divisor_i;
    logic                 busy_o;
    logic                 done_o;
    logic [DATA_SIZE-1:0] quotient_o;
    logic [DATA_SIZE-1:0] remainder_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );

endinterface

// File: rtl/seq_restoring_divider_subtractor.sv
// Combinational ripple-borrow subtractor (a_i - b_i) built from a chain of
// full subtractors; used for the divider's trial subtraction.
module ripple_borrow_subtractor #(
    parameter int DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] diff_o,
    output logic                 borrow_o
);

    logic [DATA_SIZE:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < DATA_SIZE; i++) begin : g_fs
        assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
        assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
    end

    assign borrow_o = borrow[DATA_SIZE];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    seq_restoring_divider_if.slave bus
);

    // state  | meaning
    // S_IDLE | waiting for start_i, results held
    // S_CALC | one restoring iteration per cycle
    // S_DONE | results just written, done_o pulse, may accept again

    localparam int CW = cnt_width(DATA_SIZE);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [DATA_SIZE-1:0] prem;
    logic [DATA_SIZE-1:0] dvd;
    logic [DATA_SIZE-1:0] dvs;
    logic [DATA_SIZE-1:0] quo;
    logic [DATA_SIZE-1:0] rem_out;
    logic                 dbz;

    logic                 accept;
    logic                 zero_div;
    logic                 last_iter;
    logic [DATA_SIZE:0]   shifted;
    logic [DATA_SIZE:0]   trial_diff;
    logic                 trial_borrow;
    logic [DATA_SIZE-1:0] prem_nxt;
    logic [DATA_SIZE-1:0] dvd_nxt;
    logic [DATA_SIZE-1:0] dividend_mag;
    logic [DATA_SIZE-1:0] divisor_mag;
    logic [DATA_SIZE-1:0] q_res;
    logic [DATA_SIZE-1:0] r_res;
    logic                 unused_diff_msb;

    assign accept    = (state == S_IDLE || state == S_DONE) && bus.start_i;
    assign zero_div  = (bus.divisor_i == '0);
    assign last_iter = (state == S_CALC) && (cnt == CW'(DATA_SIZE - 1));

    // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
    assign shifted = {prem, dvd[DATA_SIZE-1]};

    ripple_borrow_subtractor #(.DATA_SIZE(DATA_SIZE + 1)) u_trial_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvs}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // a kept difference is below the divisor, so its top bit is always zero
    assign unused_diff_msb = trial_diff[DATA_SIZE];
    assign prem_nxt = trial_borrow ? shifted[DATA_SIZE-1:0] : trial_diff[DATA_SIZE-1:0];
    assign dvd_nxt  = {dvd[DATA_SIZE-2:0], ~trial_borrow};

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        dividend_mag = bus.dividend_i;
        divisor_mag  = bus.divisor_i;
        q_res        = dvd_nxt;
        r_res        = prem_nxt;
        if (bus.dividend_i[DATA_SIZE-1]) dividend_mag = '0 - bus.dividend_i;
        if (bus.divisor_i[DATA_SIZE-1])  divisor_mag  = '0 - bus.divisor_i;
        if (neg_q) q_res = '0 - dvd_nxt;
        if (neg_r) r_res = '0 - prem_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.dividend_i[DATA_SIZE-1] ^ bus.divisor_i[DATA_SIZE-1];
            neg_r <= bus.dividend_i[DATA_SIZE-1];
        end
    end
`else
    always_comb begin
        dividend_mag = bus.dividend_i;
        divisor_mag  = bus.divisor_i;
        q_res        = dvd_nxt;
        r_res        = prem_nxt;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.start_i) state_nxt = zero_div ? S_DONE : S_CALC;
            S_CALC: if (last_iter)   state_nxt = S_DONE;
            S_DONE: begin
                state_nxt = S_IDLE;
                if (bus.start_i) state_nxt = zero_div ? S_DONE : S_CALC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            prem    <= '0;
            dvd     <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem_out <= '0;
            dbz     <= 1'b0;
        end else if (accept) begin
            dbz <= zero_div;
            if (zero_div) begin
                quo     <= '1;
                rem_out <= bus.dividend_i;
            end else begin
                dvd  <= dividend_mag;
                dvs  <= divisor_mag;
                prem <= '0;
                cnt  <= '0;
            end
        end else if (state == S_CALC) begin
            prem <= prem_nxt;
            dvd  <= dvd_nxt;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
                quo     <= q_res;
                rem_out <= r_res;
            end
        end
    end

    assign bus.busy_o        = (state == S_CALC);
    assign bus.done_o        = (state == S_DONE);
    assign bus.quotient_o    = quo;
    assign bus.remainder_o   = rem_out;
    assign bus.div_by_zero_o = dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (DATA_SIZE=8): arithmetic
// reference model with per-cycle compare plus directed literal vectors.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_restoring_divider_if #(.DATA_SIZE(W)) bus ();

    seq_restoring_divider #(.DATA_SIZE(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_DIV_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return W'(sa / sb);
`else
        return a / b;
`endif
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_DIV_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return W'(sa % sb);
`else
        return a % b;
`endif
    endfunction

    // Reference: an accepted request produces its results after a fixed delay.
    int           m_left;
    logic         m_done;
    logic         m_dbz;
    logic [W-1:0] m_q, m_r, p_q, p_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            p_q    <= '0;
            p_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                end
            end else if (bus.start_i) begin
                if (bus.divisor_i == '0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                    m_q    <= '1;
                    m_r    <= bus.dividend_i;
                end else begin
                    m_dbz  <= 1'b0;
                    p_q    <= ref_q(bus.dividend_i, bus.divisor_i);
                    p_r    <= ref_r(bus.dividend_i, bus.divisor_i);
                    m_left <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", bus.busy_o, m_left > 0);
        chk("cyc_done", bus.done_o, m_done);
        chk("cyc_quot", bus.quotient_o, m_q);
        chk("cyc_rem",  bus.remainder_o, m_r);
        chk("cyc_dbz",  bus.div_by_zero_o, m_dbz);
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Edges after the accepting edge until done_o shows, and busy cycles seen.
    task automatic wait_done(input string name, output int lat, output int busy_n);
        bit seen;
        seen   = 1'b0;
        lat    = -1;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.busy_o) busy_n++;
            if (bus.done_o) begin
                lat  = i - 1;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done within 40 cycles", name);
        end
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic edbz);
        chk({name, "_q"},       bus.quotient_o, eq);
        chk({name, "_r"},       bus.remainder_o, er);
        chk({name, "_dbz"},     bus.div_by_zero_o, edbz);
        chk({name, "_model_q"}, m_q, eq);
        chk({name, "_model_r"}, m_r, er);
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input int elat);
        int lat, busy_n;
        start_op(a, b);
        wait_done(name, lat, busy_n);
        chk({name, "_lat"}, lat, elat);
        chk({name, "_busy_cycles"}, busy_n, (elat == 0) ? 0 : W);
        expect_res(name, eq, er, edbz);
    endtask

    initial begin
        int lat, busy_n, stray;
        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", bus.busy_o, 1'b0);
        chk("reset_done", bus.done_o, 1'b0);
        expect_res("reset", 8'd0, 8'd0, 1'b0);

`ifdef SIGNED_DIV_EN
        run_div("s_neg100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, W);
        run_div("s_min_m1",   8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W);
        run_div("s_17_m5",    8'd17, 8'hFB, 8'hFD, 8'h02, 1'b0, W);
        run_div("div0",       8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
        run_div("s_9_3",      8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W);
`else
        run_div("d200_7",  8'd200, 8'd7,   8'd28,  8'd4, 1'b0, W);
        run_div("div0",    8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 0);
        run_div("d9_3",    8'd9,   8'd3,   8'd3,   8'd0, 1'b0, W);
        run_div("d3_10",   8'd3,   8'd10,  8'd0,   8'd3, 1'b0, W);
        run_div("d255_1",  8'd255, 8'd1,   8'd255, 8'd0, 1'b0, W);
        run_div("d255_255",8'd255, 8'd255, 8'd1,   8'd0, 1'b0, W);
`endif

        // start pulse mid-calculation with other operands must be ignored
        start_op(8'd50, 8'd6);
        repeat (3) @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = 8'd77;
        bus.divisor_i  = 8'd5;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_done("mid_start", lat, busy_n);
        chk("mid_start_lat", lat, W - 4);
        expect_res("mid_start", 8'd8, 8'd2, 1'b0);

        // start held through CALC and into DONE: back-to-back accept
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = 8'd100;
        bus.divisor_i  = 8'd7;
        @(posedge clk);
        #1;
        wait_done("b2b_first", lat, busy_n);
        chk("b2b_first_lat", lat, W);
        expect_res("b2b_first", 8'd14, 8'd2, 1'b0);
        bus.dividend_i = 8'd60;
        bus.divisor_i  = 8'd7;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_done("b2b_second", lat, busy_n);
        chk("b2b_second_lat", lat, W);
        chk("b2b_second_busy", busy_n, W);
        expect_res("b2b_second", 8'd8, 8'd4, 1'b0);

        // reset in the middle of an operation
        start_op(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy_o, 1'b0);
        chk("abort_done", bus.done_o, 1'b0);
        expect_res("abort", 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done_o) stray++;
        end
        chk("abort_no_done", stray, 0);
        run_div("d100_9", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, W);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
